// File: rtl/mmio_data_fifo_pkg.sv
// Shared types and defaults for the MMIO data FIFO.
package mmio_fifo_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 16;
  localparam int CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;

  typedef logic [63:0] t_fifo_data;

  // Layout of the FIFO status CSR for the default depth.
  typedef struct packed {
    logic                 overflow;
    logic                 underflow;
    logic                 full;
    logic                 empty;
    logic [CNT_W_DEF-1:0] count;
  } t_fifo_status;

  // Packs the exported status signals into the CSR layout.
  function automatic t_fifo_status pack_status(input logic                 ovf,
                                               input logic                 unf,
                                               input logic                 full,
                                               input logic                 empty,
                                               input logic [CNT_W_DEF-1:0] cnt);
    t_fifo_status s;
    s.overflow  = ovf;
    s.underflow = unf;
    s.full      = full;
    s.empty     = empty;
    s.count     = cnt;
    return s;
  endfunction

endpackage

// File: rtl/mmio_data_fifo_if.sv
// Host-side bundle for the MMIO data FIFO: write decode, read response and status.
// Optional MMIO_DATA_FIFO_STATS_EN adds push_cnt/drop_cnt.
interface mmio_data_fifo_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;
`ifdef MMIO_DATA_FIFO_STATS_EN
  logic [31:0]       push_cnt;
  logic [31:0]       drop_cnt;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow,
           push_cnt, drop_cnt
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, count, overflow, underflow,
           push_cnt, drop_cnt
  );
`else
  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
`endif
endinterface

// File: rtl/mmio_data_fifo_ram.sv
// Storage for the MMIO data FIFO: one write port, one registered read port, no reset.
// A same-cycle read and write of one address returns the old contents.
module mmio_fifo_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and synchronous read port; output holds when not reading.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mmio_data_fifo.sv
// Circular FIFO between MMIO write decode and MMIO read response.
// Every read of the data CSR gets a response one cycle later; an empty read returns 0.
// Optional MMIO_DATA_FIFO_STATS_EN adds saturating push/drop counters.
module mmio_data_fifo
  import mmio_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mmio_data_fifo_if.slave bus_s
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_valid_q;
  logic              data_ok_q, data_ok_d;
  logic              full, empty;
  logic              push_ok, pop_ok, ovf_set, unf_set;
  logic [DATA_W-1:0] ram_rdata;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Accept/drop decisions for this cycle.
  always_comb begin
    push_ok = bus_s.wr_en && (!full || bus_s.rd_en);
    pop_ok  = bus_s.rd_en && !empty;
    ovf_set = bus_s.wr_en && full && !bus_s.rd_en;
    unf_set = bus_s.rd_en && empty;
  end

  // Next pointers, occupancy, sticky flags and read-data select.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    data_ok_d = data_ok_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);

    if (bus_s.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (ovf_set) ovf_d = 1'b1;
      if (unf_set) unf_d = 1'b1;
    end

    // An empty pop forces the response to zero; a real pop selects the RAM output.
    if (pop_ok)       data_ok_d = 1'b1;
    else if (unf_set) data_ok_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      data_ok_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= bus_s.rd_en;
      data_ok_q  <= data_ok_d;
    end
  end

  mmio_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus_s.wr_data),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus_s.rd_data   = data_ok_q ? ram_rdata : '0;
  assign bus_s.rd_valid  = rd_valid_q;
  assign bus_s.full      = full;
  assign bus_s.empty     = empty;
  assign bus_s.count     = count_q;
  assign bus_s.overflow  = ovf_q;
  assign bus_s.underflow = unf_q;

`ifdef MMIO_DATA_FIFO_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating statistics; overflow drops and underflow pops never coincide.
  always_comb begin
    push_cnt_d = push_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (bus_s.clr_err) begin
      push_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (push_ok && (push_cnt_q != 32'hFFFF_FFFF))
        push_cnt_d = push_cnt_q + 32'd1;
      if ((ovf_set || unf_set) && (drop_cnt_q != 32'hFFFF_FFFF))
        drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus_s.push_cnt = push_cnt_q;
  assign bus_s.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mmio_data_fifo.sv
// Directed bench for mmio_data_fifo with a read-response scoreboard.
module tb_mmio_data_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [DATA_W-1:0] sb[$];

  mmio_data_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mmio_data_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_s (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every rd_valid must match the oldest expected read data.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no response", bus.rd_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = sb.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", bus.rd_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    step();
    idle();
  endtask

  task automatic pop(input logic [63:0] exp);
    sb.push_back(exp);
    bus.rd_en = 1'b1;
    step();
    idle();
  endtask

  task automatic pushpop(input logic [63:0] d, input logic [63:0] exp);
    sb.push_back(exp);
    bus.wr_en = 1'b1; bus.wr_data = d; bus.rd_en = 1'b1;
    step();
    idle();
  endtask

  task automatic clr();
    bus.clr_err = 1'b1;
    step();
    idle();
  endtask

  task automatic drain_sb();
    step();
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle();
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", bus.rd_data, 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_unf", 64'(bus.underflow), 64'd0);
    rst = 1'b0;
    step();

    // 1: three pushes, three pops
    push(64'hA1); push(64'hA2); push(64'hA3);
    chk("t1_count3", 64'(bus.count), 64'd3);
    pop(64'hA1);
    pop(64'hA2);
    pop(64'hA3);
    chk("t1_count0", 64'(bus.count), 64'd0);
    chk("t1_empty", 64'(bus.empty), 64'd1);
    drain_sb();

    // 2: fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push(64'(i));
    chk("t2_full", 64'(bus.full), 64'd1);
    chk("t2_ovf_pre", 64'(bus.overflow), 64'd0);
    push(64'hFF);
    chk("t2_ovf", 64'(bus.overflow), 64'd1);
    chk("t2_count16", 64'(bus.count), 64'd16);
    for (int i = 0; i < DEPTH; i++) pop(64'(i));
    chk("t2_empty", 64'(bus.empty), 64'd1);
    chk("t2_count0", 64'(bus.count), 64'd0);
    clr();
    chk("t2_ovf_clr", 64'(bus.overflow), 64'd0);
    drain_sb();

    // 3: empty pop, clear, clear priority over same-cycle set
    pop(64'd0);
    chk("t3_unf", 64'(bus.underflow), 64'd1);
    chk("t3_count", 64'(bus.count), 64'd0);
    clr();
    chk("t3_unf_clr", 64'(bus.underflow), 64'd0);
    sb.push_back(64'd0);
    bus.rd_en = 1'b1; bus.clr_err = 1'b1;
    step();
    idle();
    chk("t3_clr_prio", 64'(bus.underflow), 64'd0);
    drain_sb();

    // 4: full FIFO, simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push(64'(i));
    pushpop(64'h55, 64'd0);
    chk("t4_count", 64'(bus.count), 64'd16);
    chk("t4_ovf", 64'(bus.overflow), 64'd0);
    for (int i = 1; i < DEPTH; i++) pop(64'(i));
    pop(64'h55);
    chk("t4_empty", 64'(bus.empty), 64'd1);
    drain_sb();

    // 4b: empty FIFO, simultaneous push and pop
    pushpop(64'h66, 64'd0);
    chk("t4b_count", 64'(bus.count), 64'd1);
    chk("t4b_unf", 64'(bus.underflow), 64'd1);
    pop(64'h66);
    clr();
    drain_sb();

    // 5: reset mid-stream, then pointer wrap
    for (int i = 0; i < 8; i++) push(64'h100 + 64'(i));
    chk("t5_count8", 64'(bus.count), 64'd8);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    step();
    chk("t5_rst_count", 64'(bus.count), 64'd0);
    chk("t5_rst_empty", 64'(bus.empty), 64'd1);
    pop(64'd0);
    chk("t5_unf", 64'(bus.underflow), 64'd1);
    clr();
    push(64'h200);
    for (int i = 1; i <= 40; i++) pushpop(64'h200 + 64'(i), 64'h200 + 64'(i - 1));
    chk("t5_wrap_count", 64'(bus.count), 64'd1);
    pop(64'h228);
    chk("t5_wrap_empty", 64'(bus.empty), 64'd1);
    chk("t5_ovf", 64'(bus.overflow), 64'd0);
    drain_sb();

`ifdef MMIO_DATA_FIFO_STATS_EN
    // 6: statistics counters
    clr();
    chk("t6_push_clr0", 64'(bus.push_cnt), 64'd0);
    pop(64'd0);
    for (int i = 0; i < 17; i++) push(64'h300 + 64'(i));
    chk("t6_push_cnt", 64'(bus.push_cnt), 64'd16);
    chk("t6_drop_cnt", 64'(bus.drop_cnt), 64'd2);
    clr();
    chk("t6_push_clr", 64'(bus.push_cnt), 64'd0);
    chk("t6_drop_clr", 64'(bus.drop_cnt), 64'd0);
    for (int i = 0; i < DEPTH; i++) pop(64'h300 + 64'(i));
    drain_sb();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
